rgmii_tx_phy_if: RTL and testbench

- Transmit-side RGMII adapter: converts the MAC's GMII-style byte stream into the per-cycle DDR half-words (rising/falling) consumed by the team's source-synchronous DDR output stage (ODDR-based, feeding TXD/TX_CTL/TXC pins).
- Generates the TXC pattern and the MAC clock-enable for 1000/100/10 Mb/s.
- Runs on the 125 MHz transmit clock; the 90° TXC skew is applied downstream, not here.

---
 rtl/rgmii_pkg.sv | 36 +++
 rtl/rgmii_tx_phy_if_if.sv | 21 ++
 rtl/rgmii_tx_clk_gen.sv | 69 ++++++
 rtl/rgmii_tx_phy_if.sv | 130 +++++++++++++
 tb/tb_rgmii_tx_phy_if.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/rgmii_pkg.sv
// rtl/rgmii_pkg.sv - speed/state encodings, periods and TXC patterns for the RGMII transmit adapter
// Honours RGMII_TX_10M_EN: when undefined, speed 2'b00 decodes as 100M.
package rgmii_pkg;

    typedef enum logic [1:0] {
        SPEED_10   = 2'b00,
        SPEED_100  = 2'b01,
        SPEED_1000 = 2'b10
    } speed_e;

    typedef enum logic [1:0] {
        S_GIG = 2'b00,
        S_LO  = 2'b01,
        S_HI  = 2'b10
    } state_e;

    localparam int P100 = 5;
    localparam int P10  = 50;

    // bit n holds the TXC half-level for counter value n at 100M
    localparam logic [7:0] TXC1_100 = 8'b0000_0111;
    localparam logic [7:0] TXC2_100 = 8'b0000_0011;

    function automatic speed_e speed_decode(input logic [1:0] s);
        case (s)
            2'b01:   return SPEED_100;
`ifdef RGMII_TX_10M_EN
            2'b00:   return SPEED_10;
`else
            2'b00:   return SPEED_100;
`endif
            default: return SPEED_1000;
        endcase
    endfunction

endpackage

// File: rtl/rgmii_tx_phy_if_if.sv
// rtl/rgmii_tx_phy_if_if.sv - GMII-style transmit byte interface between MAC and RGMII adapter
interface rgmii_tx_phy_if_if;
    logic [7:0] mac_gmii_txd;
    logic       mac_gmii_tx_en;
    logic       mac_gmii_tx_er;
    logic       mac_gmii_tx_clk_en;

    modport master (
        output mac_gmii_txd,
        output mac_gmii_tx_en,
        output mac_gmii_tx_er,
        input  mac_gmii_tx_clk_en
    );

    modport slave (
        input  mac_gmii_txd,
        input  mac_gmii_tx_en,
        input  mac_gmii_tx_er,
        output mac_gmii_tx_clk_en
    );
endinterface

// File: rtl/rgmii_tx_clk_gen.sv
// rtl/rgmii_tx_clk_gen.sv - nibble-period counter, wrap detect, half-period flag and TXC pattern
// Honours RGMII_TX_10M_EN: without it the counter is 3 bits and only the 100M pattern exists.
module rgmii_tx_clk_gen
    import rgmii_pkg::*;
#(
    parameter int CNT_W = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_gig,
    input  logic i_load,
`ifdef RGMII_TX_10M_EN
    input  logic i_is10,
    input  logic i_load_is10,
`endif
    output logic o_wrap,
    output logic o_second_half,
    output logic o_txc_1,
    output logic o_txc_2
);

`ifdef RGMII_TX_10M_EN
    localparam int W = CNT_W;
`else
    localparam int W = 3;
`endif

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_last;
    logic [W-1:0] w_load_val;
    logic         w_txc_100_1;
    logic         w_txc_100_2;

`ifdef RGMII_TX_10M_EN
    assign w_last        = i_is10 ? W'(P10 - 1) : W'(P100 - 1);
    assign w_load_val    = i_load_is10 ? W'(P10 - 1) : W'(P100 - 1);
    assign o_second_half = (r_cnt >= (i_is10 ? W'(P10 / 2) : W'(P100 / 2)));
`else
    assign w_last        = W'(P100 - 1);
    assign w_load_val    = W'(P100 - 1);
    assign o_second_half = (r_cnt >= W'(P100 / 2));
`endif

    assign o_wrap      = !i_gig && (r_cnt == w_last);
    assign w_txc_100_1 = TXC1_100[r_cnt[2:0]];
    assign w_txc_100_2 = TXC2_100[r_cnt[2:0]];

`ifdef RGMII_TX_10M_EN
    // at 10M TXC is simply high for the first half of the nibble
    assign o_txc_1 = i_is10 ? !o_second_half : w_txc_100_1;
    assign o_txc_2 = i_is10 ? !o_second_half : w_txc_100_2;
`else
    assign o_txc_1 = w_txc_100_1;
    assign o_txc_2 = w_txc_100_2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= w_load_val;
        end else if (i_gig || o_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rgmii_tx_phy_if.sv
// rtl/rgmii_tx_phy_if.sv - GMII byte stream to RGMII DDR half-words plus TXC and MAC clock-enable
// Honours RGMII_TX_10M_EN to add 10M support; otherwise 10M requests run at 100M.
module rgmii_tx_phy_if
    import rgmii_pkg::*;
#(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       speed,
    rgmii_tx_phy_if_if.slave gmii,
    output logic [3:0]       txd_1,
    output logic [3:0]       txd_2,
    output logic             tx_ctl_1,
    output logic             tx_ctl_2,
    output logic             txc_1,
    output logic             txc_2
);

    state_e     r_state;
    state_e     w_state_nxt;
    speed_e     r_speed;
    speed_e     w_speed_in;
    logic [7:0] r_byte;
    logic       r_en;
    logic       r_er;
    logic       w_wrap;
    logic       w_second_half;
    logic       w_txc_1;
    logic       w_txc_2;
    logic       w_accept;
    logic       w_speed_ld;
    logic       w_cnt_load;
    logic       w_ctl;
    logic [3:0] w_nibble;

    assign w_speed_in = speed_decode(speed);
    assign w_accept   = (r_state == S_GIG) || ((r_state == S_HI) && w_wrap);
    // rate changes only at a byte boundary between frames
    assign w_speed_ld = w_accept && !r_en;
    assign gmii.mac_gmii_tx_clk_en = w_accept;

    rgmii_tx_clk_gen #(
        .CNT_W(CNT_W)
    ) u_clk_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_gig        (r_state == S_GIG),
        .i_load       (w_cnt_load),
`ifdef RGMII_TX_10M_EN
        .i_is10       (r_speed == SPEED_10),
        .i_load_is10  (w_speed_in == SPEED_10),
`endif
        .o_wrap       (w_wrap),
        .o_second_half(w_second_half),
        .o_txc_1      (w_txc_1),
        .o_txc_2      (w_txc_2)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_load  = 1'b0;
        case (r_state)
            S_GIG: begin
                // land on the last S_HI count so the first strobe is immediate
                if (w_speed_ld && (w_speed_in != SPEED_1000)) begin
                    w_state_nxt = S_HI;
                    w_cnt_load  = 1'b1;
                end
            end
            S_LO: begin
                if (w_wrap) w_state_nxt = S_HI;
            end
            S_HI: begin
                if (w_wrap) begin
                    w_state_nxt = (w_speed_ld && (w_speed_in == SPEED_1000)) ? S_GIG : S_LO;
                end
            end
            default: w_state_nxt = S_GIG;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_GIG;
            r_speed <= SPEED_1000;
            r_byte  <= '0;
            r_en    <= 1'b0;
            r_er    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_speed_ld) r_speed <= w_speed_in;
            if (w_accept) begin
                r_byte <= gmii.mac_gmii_txd;
                r_en   <= gmii.mac_gmii_tx_en;
                r_er   <= gmii.mac_gmii_tx_er;
            end
        end
    end

    assign w_nibble = (r_state == S_HI) ? r_byte[7:4] : r_byte[3:0];
    assign w_ctl    = w_second_half ? (r_en ^ r_er) : r_en;

    always_comb begin
        txd_1    = '0;
        txd_2    = '0;
        tx_ctl_1 = 1'b0;
        tx_ctl_2 = 1'b0;
        txc_1    = 1'b1;
        txc_2    = 1'b0;
        case (r_state)
            S_GIG: begin
                txd_1    = r_byte[3:0];
                txd_2    = r_byte[7:4];
                tx_ctl_1 = r_en;
                tx_ctl_2 = r_en ^ r_er;
            end
            S_LO, S_HI: begin
                txd_1    = w_nibble;
                txd_2    = w_nibble;
                tx_ctl_1 = w_ctl;
                tx_ctl_2 = w_ctl;
                txc_1    = w_txc_1;
                txc_2    = w_txc_2;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rgmii_tx_phy_if.sv
// tb/tb_rgmii_tx_phy_if.sv - scoreboard bench for rgmii_tx_phy_if (follows RGMII_TX_10M_EN)
module tb_rgmii_tx_phy_if;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] speed;
    logic [3:0] txd_1;
    logic [3:0] txd_2;
    logic       tx_ctl_1;
    logic       tx_ctl_2;
    logic       txc_1;
    logic       txc_2;

    rgmii_tx_phy_if_if u_if ();

    rgmii_tx_phy_if #(
        .CNT_W(7)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .speed   (speed),
        .gmii    (u_if),
        .txd_1   (txd_1),
        .txd_2   (txd_2),
        .tx_ctl_1(tx_ctl_1),
        .tx_ctl_2(tx_ctl_2),
        .txc_1   (txc_1),
        .txc_2   (txc_2)
    );

    always #4 clk = ~clk;

`ifdef RGMII_TX_10M_EN
    localparam int MDL10 = 10;
`else
    localparam int MDL10 = 100;
`endif

    // {clk_en, txd_1, txd_2, tx_ctl_1, tx_ctl_2, txc_1, txc_2}
    localparam logic [12:0] RESET_VEC = 13'b1_0000_0000_0010;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [12:0] exp_q[$];
    logic [7:0]  stim_q[$];
    int          gap;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] obs_now();
        return {u_if.mac_gmii_tx_clk_en, txd_1, txd_2, tx_ctl_1, tx_ctl_2, txc_1, txc_2};
    endfunction

    task automatic drive(input logic [7:0] b, input logic en, input logic er);
        u_if.mac_gmii_txd   = b;
        u_if.mac_gmii_tx_en = en;
        u_if.mac_gmii_tx_er = er;
    endtask

    task automatic push_exp(input int mdl, input logic [7:0] b, input logic en, input logic er);
        int p;
        if (mdl == 1000) begin
            exp_q.push_back({1'b1, b[3:0], b[7:4], en, en ^ er, 1'b1, 1'b0});
        end else begin
            p = (mdl == 100) ? 5 : 50;
            for (int c = 0; c < 2 * p; c++) begin
                int         cnt;
                logic [3:0] nib;
                logic       ctl, t1, t2, ce;
                cnt = c % p;
                nib = (c < p) ? b[3:0] : b[7:4];
                ctl = (cnt < p / 2) ? en : (en ^ er);
                t1  = (mdl == 100) ? (cnt < 3) : (cnt < 25);
                t2  = (mdl == 100) ? (cnt < 2) : (cnt < 25);
                ce  = (c == 2 * p - 1);
                exp_q.push_back({ce, nib, nib, ctl, ctl, t1, t2});
            end
        end
    endtask

    task automatic run_bytes(input string tag, input logic [1:0] pin_spd, input int mdl,
                             input logic en, input logic er,
                             input int chg_idx, input logic [1:0] chg_spd);
        int n, idx, cyc, budget;
        logic [12:0] e;
        n      = stim_q.size();
        idx    = 0;
        budget = (n + 2) * ((mdl == 1000) ? 2 : (mdl == 100) ? 10 : 100) + 40;
        speed  = pin_spd;
        for (cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(tag, {3'b0, obs_now()}, {3'b0, e});
            end
            if (u_if.mac_gmii_tx_clk_en) begin
                if (idx < n) begin
                    drive(stim_q[idx], en, er);
                    if (idx == chg_idx) speed = chg_spd;
                    push_exp(mdl, stim_q[idx], en, er);
                    idx++;
                end else begin
                    drive(8'h00, 1'b0, 1'b0);
                end
            end
            if (idx == n && exp_q.size() == 0) break;
        end
        chk({tag, "_drained"}, {15'b0, (idx == n) && (exp_q.size() == 0)}, 16'd1);
        exp_q.delete();
    endtask

    task automatic wait_strobe(output int g);
        g = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (u_if.mac_gmii_tx_clk_en) begin
                g = i;
                break;
            end
        end
    endtask

    task automatic set_speed(input logic [1:0] s, input int cycles);
        speed = s;
        drive(8'h00, 1'b0, 1'b0);
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        speed = 2'b10;
        drive(8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk("reset_hold", {3'b0, obs_now()}, {3'b0, RESET_VEC});
        @(negedge clk);
        rst_n = 1'b1;

        stim_q = '{8'h55, 8'hD5, 8'hA7};
        run_bytes("gig", 2'b10, 1000, 1'b1, 1'b0, -1, 2'b10);
        stim_q = '{8'hE1, 8'h0F};
        run_bytes("gig_sp11_err", 2'b11, 1000, 1'b1, 1'b1, -1, 2'b11);

        // speed request arrives mid-frame; must wait for tx_en to drop
        stim_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_bytes("gig_midframe", 2'b10, 1000, 1'b1, 1'b0, 2, 2'b01);
        @(negedge clk);
        chk("drop_still_gig", {3'b0, obs_now()}, {3'b0, RESET_VEC});
        @(negedge clk);
        chk("drop_first_strobe", {3'b0, obs_now()}, 16'h1000);
        wait_strobe(gap);
        chk("drop_strobe_gap", gap[15:0], 16'd10);

        stim_q = '{8'h3C};
        run_bytes("fast_err", 2'b01, 100, 1'b1, 1'b1, -1, 2'b01);
        stim_q = '{8'hA5, 8'h81};
        run_bytes("fast", 2'b01, 100, 1'b1, 1'b0, -1, 2'b01);

        set_speed(2'b00, 150);
        stim_q = '{8'h96};
        run_bytes("slow", 2'b00, MDL10, 1'b1, 1'b1, -1, 2'b00);

        set_speed(2'b10, 220);
        stim_q = '{8'h5D};
        run_bytes("gig_back", 2'b10, 1000, 1'b1, 1'b0, -1, 2'b10);

        // reset in the middle of a low nibble
        set_speed(2'b01, 30);
        wait_strobe(gap);
        chk("rst_pre_strobe", {15'b0, u_if.mac_gmii_tx_clk_en}, 16'd1);
        drive(8'h5A, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre_lo", {3'b0, obs_now()}, 16'b000_0_1010_1010_1111);
        drive(8'h00, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", {3'b0, obs_now()}, {3'b0, RESET_VEC});
        speed = 2'b10;
        @(negedge clk);
        chk("rst_held", {3'b0, obs_now()}, {3'b0, RESET_VEC});
        rst_n = 1'b1;
        stim_q = '{8'hC3, 8'h7E};
        run_bytes("gig_after_rst", 2'b10, 1000, 1'b1, 1'b0, -1, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
